fnn_mac_sequencer: RTL and testbench

- Sequences a single shared multiply-accumulate datapath through both FNN layers for one sample: hidden (N_HID neurons × N_IN inputs), then output (N_OUT neurons × N_HID inputs).
- Generates weight/bias addresses, input indices, MAC clear/enable, bias-add, activation and result-write strobes.
- Sits between the top-level sample controller (start/done handshake) and the MAC datapath, its weight ROM (1-cycle read latency) and its bias ROM (combinational).

---
 rtl/fnn_pkg.sv | 36 +++
 rtl/fnn_mac_sequencer_if.sv | 36 +++
 rtl/fnn_addr_gen.sv | 38 +++
 rtl/fnn_mac_sequencer.sv | 133 +++++++++++++
 tb/tb_fnn_mac_sequencer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/fnn_pkg.sv
// Shared constants, state encoding and address helpers for the FNN
// MAC sequencer.
package fnn_pkg;

   localparam int N_IN_DEF  = 62;
   localparam int N_HID_DEF = 30;
   localparam int N_OUT_DEF = 10;

   localparam int W_ADDR_W_DEF =
      $clog2(N_HID_DEF * N_IN_DEF + N_OUT_DEF * N_HID_DEF);
   localparam int B_ADDR_W_DEF = $clog2(N_HID_DEF + N_OUT_DEF);
   localparam int IDX_W_DEF    = $clog2(N_IN_DEF);

   localparam int HID_W_BASE = 0;
   localparam int OUT_W_BASE = N_HID_DEF * N_IN_DEF;
   localparam int OUT_B_BASE = N_HID_DEF;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_MAC   = 3'd2,
      S_DRAIN = 3'd3,
      S_BIAS  = 3'd4,
      S_WRITE = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   function automatic int out_w_base(int n_in, int n_hid);
      return n_hid * n_in;
   endfunction

   function automatic int out_b_base(int n_hid);
      return n_hid;
   endfunction

endpackage

// File: rtl/fnn_mac_sequencer_if.sv
// Sample handshake plus MAC datapath control bundle driven by the
// sequencer.
interface fnn_mac_sequencer_if #(
   parameter int W_ADDR_W = 12,
   parameter int B_ADDR_W = 6,
   parameter int IDX_W    = 6
);
   logic                start;
   logic                busy;
   logic                done;
   logic                layer_sel;
   logic [IDX_W-1:0]    in_idx;
   logic [W_ADDR_W-1:0] w_addr;
   logic [B_ADDR_W-1:0] b_addr;
   logic                mac_clr;
   logic                mac_en;
   logic                bias_add;
   logic                act_en;
   logic                wr_hid;
   logic                wr_out;
   logic [IDX_W-1:0]    out_idx;

   modport master (
      input  start,
      output busy, done, layer_sel, in_idx, w_addr, b_addr,
      output mac_clr, mac_en, bias_add, act_en, wr_hid, wr_out,
      output out_idx
   );

   modport slave (
      output start,
      input  busy, done, layer_sel, in_idx, w_addr, b_addr,
      input  mac_clr, mac_en, bias_add, act_en, wr_hid, wr_out,
      input  out_idx
   );
endinterface

// File: rtl/fnn_addr_gen.sv
// Maps layer / neuron j / operand k onto weight and bias ROM
// addresses.
module fnn_addr_gen
   import fnn_pkg::*;
#(
   parameter int N_IN     = N_IN_DEF,
   parameter int N_HID    = N_HID_DEF,
   parameter int W_ADDR_W = W_ADDR_W_DEF,
   parameter int B_ADDR_W = B_ADDR_W_DEF,
   parameter int IDX_W    = IDX_W_DEF
) (
   input  logic                layer_sel,
   input  logic [IDX_W-1:0]    j,
   input  logic [IDX_W-1:0]    k,
   output logic [W_ADDR_W-1:0] w_addr,
   output logic [B_ADDR_W-1:0] b_addr
);

   localparam int OW = out_w_base(N_IN, N_HID);
   localparam int OB = out_b_base(N_HID);

   int w_full;
   int b_full;

   always_comb begin
      if (layer_sel) begin
         w_full = OW + int'(j) * N_HID + int'(k);
         b_full = OB + int'(j);
      end else begin
         w_full = HID_W_BASE + int'(j) * N_IN + int'(k);
         b_full = int'(j);
      end
   end

   assign w_addr = W_ADDR_W'(w_full);
   assign b_addr = B_ADDR_W'(b_full);

endmodule

// File: rtl/fnn_mac_sequencer.sv
// Drives one shared MAC datapath through the hidden then output layer
// of a single sample.
module fnn_mac_sequencer
   import fnn_pkg::*;
#(
   parameter int N_IN     = N_IN_DEF,
   parameter int N_HID    = N_HID_DEF,
   parameter int N_OUT    = N_OUT_DEF,
   parameter int W_ADDR_W = W_ADDR_W_DEF,
   parameter int B_ADDR_W = B_ADDR_W_DEF,
   parameter int IDX_W    = IDX_W_DEF
) (
   input logic                 clk,
   input logic                 rst,
   fnn_mac_sequencer_if.master bus
);

   if (N_HID * N_IN + N_OUT * N_HID > (1 << W_ADDR_W)) begin : g_w_chk
      $error("W_ADDR_W too narrow");
   end
   if (N_HID + N_OUT > (1 << B_ADDR_W)) begin : g_b_chk
      $error("B_ADDR_W too narrow");
   end
   if (N_IN > (1 << IDX_W) || N_HID > (1 << IDX_W) ||
       N_OUT > (1 << IDX_W)) begin : g_i_chk
      $error("IDX_W too narrow");
   end

   state_t           state, state_nx;
   logic [IDX_W-1:0] j, j_nx, k, k_nx, in_idx_q;
   logic             layer, layer_nx, mac_en_q;
   logic             last_k, last_j;

   assign last_k = layer ? (k == IDX_W'(N_HID - 1))
                         : (k == IDX_W'(N_IN - 1));
   assign last_j = layer ? (j == IDX_W'(N_OUT - 1))
                         : (j == IDX_W'(N_HID - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         j        <= '0;
         k        <= '0;
         layer    <= 1'b0;
         mac_en_q <= 1'b0;
         in_idx_q <= '0;
      end else begin
         state    <= state_nx;
         j        <= j_nx;
         k        <= k_nx;
         layer    <= layer_nx;
         // Delay by one so the operand lines up with the ROM word.
         mac_en_q <= (state == S_MAC);
         in_idx_q <= k;
      end
   end

   always_comb begin
      state_nx = state;
      j_nx     = j;
      k_nx     = k;
      layer_nx = layer;
      unique case (state)
         S_IDLE: begin
            if (bus.start) begin
               state_nx = S_CLR;
               j_nx     = '0;
               k_nx     = '0;
               layer_nx = 1'b0;
            end
         end
         S_CLR: begin
            state_nx = S_MAC;
            k_nx     = '0;
         end
         S_MAC: begin
            if (last_k) begin
               state_nx = S_DRAIN;
               k_nx     = '0;
            end else begin
               k_nx = k + IDX_W'(1);
            end
         end
         S_DRAIN: state_nx = S_BIAS;
         S_BIAS:  state_nx = S_WRITE;
         S_WRITE: begin
            if (!last_j) begin
               state_nx = S_CLR;
               j_nx     = j + IDX_W'(1);
            end else if (!layer) begin
               state_nx = S_CLR;
               j_nx     = '0;
               layer_nx = 1'b1;
            end else begin
               state_nx = S_DONE;
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
            j_nx     = '0;
            layer_nx = 1'b0;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   fnn_addr_gen #(
      .N_IN     (N_IN),
      .N_HID    (N_HID),
      .W_ADDR_W (W_ADDR_W),
      .B_ADDR_W (B_ADDR_W),
      .IDX_W    (IDX_W)
   ) u_addr (
      .layer_sel (layer),
      .j         (j),
      .k         (k),
      .w_addr    (bus.w_addr),
      .b_addr    (bus.b_addr)
   );

   assign bus.busy      = (state != S_IDLE) && (state != S_DONE);
   assign bus.done      = (state == S_DONE);
   assign bus.layer_sel = layer;
   assign bus.in_idx    = in_idx_q;
   assign bus.mac_clr   = (state == S_CLR);
   assign bus.mac_en    = mac_en_q;
   assign bus.bias_add  = (state == S_BIAS);
   assign bus.act_en    = (state == S_WRITE) && !layer;
   assign bus.wr_hid    = (state == S_WRITE) && !layer;
   assign bus.wr_out    = (state == S_WRITE) && layer;
   assign bus.out_idx   = j;

endmodule

// File: tb/tb_fnn_mac_sequencer.sv
// Directed bench: a small 3/2/2 instance for cycle-exact vectors and a
// default 62/30/10 instance for full-sample totals.
module tb_fnn_mac_sequencer;

   localparam int SW = 8;
   localparam int SB = 4;
   localparam int SI = 4;

   logic clk;
   logic rst_s;
   logic rst_d;

   fnn_mac_sequencer_if #(.W_ADDR_W(SW), .B_ADDR_W(SB), .IDX_W(SI)) bs();
   fnn_mac_sequencer_if #(.W_ADDR_W(12), .B_ADDR_W(6), .IDX_W(6)) bd();

   fnn_mac_sequencer #(
      .N_IN(3), .N_HID(2), .N_OUT(2),
      .W_ADDR_W(SW), .B_ADDR_W(SB), .IDX_W(SI)
   ) u_s (
      .clk (clk),
      .rst (rst_s),
      .bus (bs)
   );

   fnn_mac_sequencer #(
      .N_IN(62), .N_HID(30), .N_OUT(10),
      .W_ADDR_W(12), .B_ADDR_W(6), .IDX_W(6)
   ) u_d (
      .clk (clk),
      .rst (rst_d),
      .bus (bd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {busy, done, layer_sel, mac_clr, mac_en, bias_add, act_en, wr_hid, wr_out}
   logic [8:0]  fl_s;
   logic [28:0] all_s;
   assign fl_s  = {bs.busy, bs.done, bs.layer_sel, bs.mac_clr, bs.mac_en,
                   bs.bias_add, bs.act_en, bs.wr_hid, bs.wr_out};
   assign all_s = {fl_s, bs.in_idx, bs.w_addr, bs.b_addr, bs.out_idx};

   typedef struct {
      logic [8:0] fl;
      int         w;
      int         b;
      int         ii;
      int         oi;
   } vec_t;

   vec_t tv[27];

   int checks = 0;
   int errors = 0;

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic start_small();
      @(negedge clk);
      bs.start = 1'b1;
      @(posedge clk);
   endtask

   task automatic run_small(output int lat, output int en);
      lat = -1;
      en  = 0;
      start_small();
      for (int n = 0; n < 100 && lat < 0; n++) begin
         @(negedge clk);
         bs.start = 1'b0;
         if (bs.mac_en) en++;
         if (bs.done) lat = n;
      end
   endtask

   int en, lat, wr, dn, d1, d2, dc, b27, c28;
   int hid, outc, wmax, blast, viol, nstr;

   initial begin
      tv[0]  = '{9'b100100000, -1, 0, -1, 0};
      tv[1]  = '{9'b100000000,  0, 0, -1, 0};
      tv[2]  = '{9'b100010000,  1, 0,  0, 0};
      tv[3]  = '{9'b100010000,  2, 0,  1, 0};
      tv[4]  = '{9'b100010000, -1, 0,  2, 0};
      tv[5]  = '{9'b100001000, -1, 0, -1, 0};
      tv[6]  = '{9'b100000110, -1, 0, -1, 0};
      tv[7]  = '{9'b100100000, -1, 1, -1, 1};
      tv[8]  = '{9'b100000000,  3, 1, -1, 1};
      tv[9]  = '{9'b100010000,  4, 1,  0, 1};
      tv[10] = '{9'b100010000,  5, 1,  1, 1};
      tv[11] = '{9'b100010000, -1, 1,  2, 1};
      tv[12] = '{9'b100001000, -1, 1, -1, 1};
      tv[13] = '{9'b100000110, -1, 1, -1, 1};
      tv[14] = '{9'b101100000, -1, 2, -1, 0};
      tv[15] = '{9'b101000000,  6, 2, -1, 0};
      tv[16] = '{9'b101010000,  7, 2,  0, 0};
      tv[17] = '{9'b101010000, -1, 2,  1, 0};
      tv[18] = '{9'b101001000, -1, 2, -1, 0};
      tv[19] = '{9'b101000001, -1, 2, -1, 0};
      tv[20] = '{9'b101100000, -1, 3, -1, 1};
      tv[21] = '{9'b101000000,  8, 3, -1, 1};
      tv[22] = '{9'b101010000,  9, 3,  0, 1};
      tv[23] = '{9'b101010000, -1, 3,  1, 1};
      tv[24] = '{9'b101001000, -1, 3, -1, 1};
      tv[25] = '{9'b101000001, -1, 3, -1, 1};
      tv[26] = '{9'b011000000, -1, -1, -1, -1};

      rst_s    = 1'b1;
      rst_d    = 1'b1;
      bs.start = 1'b0;
      bd.start = 1'b0;
      repeat (2) @(negedge clk);
      rst_s = 1'b0;
      rst_d = 1'b0;

      // Idle after reset
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("idle%0d outputs", i), int'(all_s), 0);
      end

      // Cycle-exact single sample
      start_small();
      en = 0;
      for (int i = 0; i < 27; i++) begin
         @(negedge clk);
         bs.start = 1'b0;
         chk($sformatf("v%0d flags", i), int'(fl_s), int'(tv[i].fl));
         if (tv[i].w >= 0)
            chk($sformatf("v%0d w_addr", i), int'(bs.w_addr), tv[i].w);
         if (tv[i].b >= 0)
            chk($sformatf("v%0d b_addr", i), int'(bs.b_addr), tv[i].b);
         if (tv[i].ii >= 0)
            chk($sformatf("v%0d in_idx", i), int'(bs.in_idx), tv[i].ii);
         if (tv[i].oi >= 0)
            chk($sformatf("v%0d out_idx", i), int'(bs.out_idx), tv[i].oi);
         if (bs.mac_en) en++;
      end
      chk("mac_en count", en, 10);

      // start while busy ignored, then held across DONE
      start_small();
      d1 = -1; d2 = -1; dc = 0; b27 = -1; c28 = -1;
      for (int n = 0; n <= 70; n++) begin
         @(negedge clk);
         bs.start = ((n >= 3 && n <= 8) || (n >= 15 && n <= 27));
         if (bs.done) begin
            dc++;
            if (d1 < 0) d1 = n;
            else if (d2 < 0) d2 = n;
         end
         if (n == 27) b27 = int'(bs.busy);
         if (n == 28) c28 = int'(bs.mac_clr);
      end
      bs.start = 1'b0;
      chk("first done", d1, 26);
      chk("second done", d2, 54);
      chk("done count", dc, 2);
      chk("busy in idle gap", b27, 0);
      chk("restart clr", c28, 1);

      // Reset during hidden-layer MAC of neuron 1
      start_small();
      for (int n = 0; n <= 9; n++) begin
         @(negedge clk);
         bs.start = 1'b0;
      end
      chk("pre-reset w_addr", int'(bs.w_addr), 4);
      rst_s = 1'b1;
      @(negedge clk);
      chk("reset abort outputs", int'(all_s), 0);
      rst_s = 1'b0;
      wr = 0;
      dn = 0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (bs.wr_hid || bs.wr_out) wr++;
         if (bs.done) dn++;
      end
      chk("writes after reset", wr, 0);
      chk("done after reset", dn, 0);
      run_small(lat, en);
      chk("post-reset latency", lat, 26);
      chk("post-reset mac_en", en, 10);

      // Full default sample
      @(negedge clk);
      bd.start = 1'b1;
      @(posedge clk);
      lat = -1; hid = 0; outc = 0; wmax = 0; blast = -1; viol = 0;
      for (int n = 0; n < 3000 && lat < 0; n++) begin
         @(negedge clk);
         bd.start = 1'b0;
         if (bd.wr_hid) hid++;
         if (bd.wr_out) begin
            outc++;
            blast = int'(bd.b_addr);
         end
         if (int'(bd.w_addr) > wmax) wmax = int'(bd.w_addr);
         nstr = int'(bd.mac_clr) + int'(bd.bias_add) +
                int'(bd.wr_hid) + int'(bd.wr_out);
         if (nstr > 1 || (bd.mac_en && nstr != 0)) viol++;
         if (bd.done) lat = n;
      end
      chk("default latency", lat, 2320);
      chk("default wr_hid", hid, 30);
      chk("default wr_out", outc, 10);
      chk("default max w_addr", wmax, 2159);
      chk("default final b_addr", blast, 39);
      chk("strobe exclusivity", viol, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
